// File: rtl/piso_serializer_if.sv
// Load and serial-side bundle for piso_serializer: word handshake, bit-rate
// tick, and the serial stream with its framing strobes.
interface piso_serializer_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] data_in;
    logic             load_valid;
    logic             load_ready;
    logic             shift_en;
    logic             serial_out;
    logic             serial_valid;
    logic             frame_start;
    logic             busy;
    logic             done;

    modport master (
        output data_in, load_valid, shift_en,
        input  load_ready, serial_out, serial_valid, frame_start, busy, done
    );

    modport slave (
        input  data_in, load_valid, shift_en,
        output load_ready, serial_out, serial_valid, frame_start, busy, done
    );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out framer feeding a downstream SIPO, one bit per shift_en tick.
// Define PISO_PARITY_EN to append an even-parity bit to every frame.
module piso_serializer #(
    parameter int   WIDTH      = 4,
    parameter int   MSB_FIRST  = 1,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    piso_serializer_if.slave bus
);
`ifdef PISO_PARITY_EN
    localparam int FRAME_LEN = WIDTH + 1;
`else
    localparam int FRAME_LEN = WIDTH;
`endif
    localparam int               CNT_W    = $clog2(FRAME_LEN + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t               state_reg;
    logic [WIDTH-1:0]     word_reg;
    logic [CNT_W-1:0]     bit_cnt_reg;
    logic [CNT_W-1:0]     bit_cnt_next;
    logic                 serial_out_reg;
    logic                 serial_valid_reg;
    logic                 frame_start_reg;
    logic                 busy_reg;
    logic                 done_reg;
    logic [FRAME_LEN-1:0] frame_bits;
    logic                 first_bit;
    logic                 next_bit;
    logic                 last_bit;
    logic                 load_ready;
    logic                 accept;

    // frame_bits holds the captured word in transmit order, so bit_cnt indexes it directly.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_order
            assign frame_bits[gi] = word_reg[(MSB_FIRST != 0) ? (WIDTH - 1 - gi) : gi];
        end
    endgenerate
`ifdef PISO_PARITY_EN
    assign frame_bits[WIDTH] = ^word_reg;
`endif

    assign first_bit    = (MSB_FIRST != 0) ? bus.data_in[WIDTH-1] : bus.data_in[0];
    assign bit_cnt_next = bit_cnt_reg + CNT_W'(1);
    assign last_bit     = (state_reg == SHIFT) && (bit_cnt_reg == LAST_CNT);
    assign load_ready   = (state_reg == IDLE) || (last_bit && bus.shift_en);
    assign accept       = load_ready && bus.load_valid;

    always_comb begin
        next_bit = IDLE_LEVEL;
        for (int i = 0; i < FRAME_LEN; i++) begin
            if (bit_cnt_next == CNT_W'(i)) begin
                next_bit = frame_bits[i];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg        <= IDLE;
            word_reg         <= '0;
            bit_cnt_reg      <= '0;
            serial_out_reg   <= IDLE_LEVEL;
            serial_valid_reg <= 1'b0;
            frame_start_reg  <= 1'b0;
            busy_reg         <= 1'b0;
            done_reg         <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (accept) begin
                // Accepting while in SHIFT means the previous frame just ended here.
                state_reg        <= SHIFT;
                word_reg         <= bus.data_in;
                bit_cnt_reg      <= '0;
                serial_out_reg   <= first_bit;
                serial_valid_reg <= 1'b1;
                frame_start_reg  <= 1'b1;
                busy_reg         <= 1'b1;
                done_reg         <= (state_reg == SHIFT);
            end else if ((state_reg == SHIFT) && bus.shift_en) begin
                if (last_bit) begin
                    state_reg        <= IDLE;
                    bit_cnt_reg      <= '0;
                    serial_out_reg   <= IDLE_LEVEL;
                    serial_valid_reg <= 1'b0;
                    frame_start_reg  <= 1'b0;
                    busy_reg         <= 1'b0;
                    done_reg         <= 1'b1;
                end else begin
                    bit_cnt_reg     <= bit_cnt_next;
                    serial_out_reg  <= next_bit;
                    frame_start_reg <= 1'b0;
                end
            end
        end
    end

    assign bus.load_ready   = load_ready;
    assign bus.serial_out   = serial_out_reg;
    assign bus.serial_valid = serial_valid_reg;
    assign bus.frame_start  = frame_start_reg;
    assign bus.busy         = busy_reg;
    assign bus.done         = done_reg;
endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Parallel-in/serial-out stage that sits directly upstream of the team's 4-bit SIPO register and drives its serial_in.
- Accepts a WIDTH-bit word over a valid/ready handshake and shifts it out one bit per shift_en tick.
- Provides framing strobes (frame_start, done) so the downstream SIPO or a checker knows when parallel_out holds a complete word.

Parameters:
- WIDTH, 4, data word width in bits; must be ≥ 2.
- MSB_FIRST, 1, 1 = bit WIDTH-1 goes out first; 0 = bit 0 goes out first.
- IDLE_LEVEL, 0, value driven on serial_out when no frame is active.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- data_in  input  WIDTH  parallel word to serialize.
- load_valid  input  1  data_in is valid.
- load_ready  output  1  block can accept a word this cycle.
- shift_en  input  1  bit-rate tick; the current bit is consumed on an edge where this is 1.
- serial_out  output  1  serial data; connects to the SIPO serial_in.
- serial_valid  output  1  serial_out carries a frame bit.
- frame_start  output  1  high while the first bit of a frame is on serial_out.
- busy  output  1  frame in progress.
- done  output  1  one-cycle pulse after the last bit of a frame is consumed.

Behaviour:
- All outputs registered except load_ready, which is combinational from state.
- Reset (reset=0, async):
  - state=IDLE; shift register and bit counter cleared.
  - serial_out=IDLE_LEVEL; serial_valid=0, frame_start=0, busy=0, done=0.
  - load_ready=1 once in IDLE.
- State IDLE:
  - load_ready=1, serial_out=IDLE_LEVEL, serial_valid=0.
  - On an edge with load_valid=1: capture data_in, bit_cnt=0, go to SHIFT.
  - Latency is 0 cycles from handshake to first bit: after the handshake edge, serial_out = first bit, serial_valid=1, frame_start=1, busy=1.
- State SHIFT:
  - The current bit is held until an edge with shift_en=1. On that edge bit_cnt increments and the next bit is presented.
  - frame_start clears on the first advance.
  - Bit order follows MSB_FIRST.
  - load_valid is ignored when load_ready=0; the captured word is never modified mid-frame.
- Last bit (bit_cnt=WIDTH-1) consumed on an edge with shift_en=1:
  - done=1 for exactly one cycle after that edge.
  - If load_valid=1 on the same edge (load_ready=1 combinationally during the last bit when shift_en=1): the new word is captured and the next frame starts immediately, with no idle cycle. Its first bit, frame_start=1 and busy=1 follow directly, and done=1 coincides with the new frame's first bit.
  - Otherwise go to IDLE: serial_out=IDLE_LEVEL, serial_valid=0, busy=0.
- load_ready = (state==IDLE) OR (state==SHIFT AND last bit AND shift_en).
- With shift_en tied to 1, a frame occupies exactly WIDTH cycles and back-to-back throughput is one word per WIDTH cycles.
- bit_cnt width is clog2(WIDTH+1) and never wraps past the frame length.
- Reset asserted mid-frame: the frame is aborted immediately (async) and all outputs take their reset values. No done pulse is produced. The first load after reset release starts a fresh frame.
- shift_en=1 in IDLE has no effect.

Optional Feature:
- Macro PISO_PARITY_EN.
- When defined:
  - After the WIDTH data bits, one extra even-parity bit (XOR of the captured word) is presented for one shift_en tick with serial_valid=1.
  - The frame is WIDTH+1 bits; the last-bit, load_ready and done rules apply to the parity bit.
  - bit_cnt is sized for WIDTH+1.
- When undefined: no parity logic is present and the frame is exactly WIDTH bits.

Test Plan:
1. WIDTH=4, MSB_FIRST=1, shift_en=1 tied. Load 4'b1001 → serial_out = 1,0,0,1 on 4 consecutive cycles; frame_start only on the first; done pulses on the 5th cycle; a downstream SIPO shows parallel_out=4'b1001 at that point.
2. Back-to-back: load 4'b1010, hold load_valid with 4'b0110 ready → second word's first bit immediately follows the last bit of the first; 8 consecutive serial_valid cycles; done pulses twice, 4 cycles apart.
3. shift_en pulsed every 3rd cycle, load 4'b1100 → each bit held 3 cycles; done only after the 4th tick; load_valid asserted mid-frame with 4'b0011 is ignored and not transmitted.
4. MSB_FIRST=0, load 4'b0001 → serial_out = 1,0,0,0.
5. Reset dropped to 0 after 2 bits of 4'b1111 → serial_out=IDLE_LEVEL, serial_valid=0, busy=0 immediately with no done pulse; after release, load 4'b0101 transmits cleanly.
6. With PISO_PARITY_EN, load 4'b1011 → serial_out = 1,0,1,1 then parity 1; done after 5 bits. Load 4'b1001 → parity bit 0.
